// File: rtl/mips_pkg.sv
// Shared definitions for the writeback stage and its iterative multiplier.
package mips_pkg;

  localparam int DATA_W = 32;

  // EX operation codes that start the multiplier
  localparam logic [3:0] ALU_MULT  = 4'b0110;
  localparam logic [3:0] ALU_MULTU = 4'b0111;

  // Writeback source select
  localparam logic [1:0] REGSEL_ALU = 2'd0;
  localparam logic [1:0] REGSEL_HI  = 2'd1;
  localparam logic [1:0] REGSEL_LO  = 2'd2;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_FIN  = 2'd2
  } mul_state_e;

  // True when the instruction reads HI or LO and so must wait for the multiplier.
  function automatic logic reads_hilo(input logic [1:0] regsel);
    return (regsel == REGSEL_HI) || (regsel == REGSEL_LO);
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, sign applied at the end.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// MUL_IDLE | waiting for start; operands latched on the start edge
// MUL_RUN  | one shift-add step per edge, MUL_STEPS steps in total
// MUL_FIN  | product valid (done = 1); caller latches it on this edge
module mul_iter #(
  parameter int DATA_W    = 32,
  parameter int MUL_STEPS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [DATA_W-1:0]     opa,
  input  logic [DATA_W-1:0]     opb,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);
  import mips_pkg::*;

  localparam int PW    = 2 * DATA_W;
  localparam int CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic              neg_q, neg_d;
  logic [DATA_W-1:0] mag_a, mag_b;

  // Operand magnitudes; the most negative value maps to 2^(DATA_W-1) as an unsigned magnitude.
  always_comb begin
    mag_a = (is_signed && opa[DATA_W-1]) ? -opa : opa;
    mag_b = (is_signed && opb[DATA_W-1]) ? -opb : opb;
  end

  // Next-state and datapath for the shift-add sequence
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    case (state_q)
      MUL_IDLE: begin
        if (start) begin
          state_d  = MUL_RUN;
          mcand_d  = {{DATA_W{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = is_signed & (opa[DATA_W-1] ^ opb[DATA_W-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      MUL_RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = MUL_FIN;
          cnt_d   = '0;
        end
      end
      MUL_FIN: begin
        state_d = MUL_IDLE;
      end
      default: begin
        state_d = MUL_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any multiply in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
    end
  end

  assign busy    = (state_q != MUL_IDLE);
  assign done    = (state_q == MUL_FIN);
  assign product = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/writeback_stage.sv
// EX/WB pipeline register with HI/LO, writeback source mux, multiplier interlock and GPIO output.
module writeback_stage #(
  parameter int DATA_W    = mips_pkg::DATA_W,
  parameter int MUL_STEPS = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        alu_op_EX,
  input  logic [DATA_W-1:0] alu_result_EX,
  input  logic [DATA_W-1:0] opa_EX,
  input  logic [DATA_W-1:0] opb_EX,
  input  logic              enhilo_EX,
  input  logic [1:0]        regsel_EX,
  input  logic              regwrite_EX,
  input  logic [4:0]        rd_EX,
  input  logic              GPIO_out_en_EX,
  output logic              stall_EX,
  output logic              regwrite_WB,
  output logic [4:0]        writeaddr_WB,
  output logic [DATA_W-1:0] writedata_WB,
  output logic [DATA_W-1:0] GPIO_OUT,
  output logic              mul_busy
);
  import mips_pkg::*;

  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                regwrite_q, regwrite_d;
  logic [4:0]          writeaddr_q, writeaddr_d;
  logic [DATA_W-1:0]   writedata_q, writedata_d;
  logic [DATA_W-1:0]   gpio_q, gpio_d;
  logic                mul_busy_w, mul_done, mul_start, accept;
  logic [2*DATA_W-1:0] mul_product;
  logic [DATA_W-1:0]   wb_src;

  mul_iter #(
    .DATA_W    (DATA_W),
    .MUL_STEPS (MUL_STEPS)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start     (mul_start),
    .is_signed (alu_op_EX == ALU_MULT),
    .opa       (opa_EX),
    .opb       (opb_EX),
    .busy      (mul_busy_w),
    .done      (mul_done),
    .product   (mul_product)
  );

  // Only HI/LO consumers and new multiplies wait; everything else flows past a busy multiplier.
  assign stall_EX  = mul_busy_w & (enhilo_EX | reads_hilo(regsel_EX));
  assign accept    = ~stall_EX;
  assign mul_start = accept & enhilo_EX;

  // Writeback source select; encoding 3 falls back to the ALU result
  always_comb begin
    case (regsel_EX)
      REGSEL_HI: wb_src = hi_q;
      REGSEL_LO: wb_src = lo_q;
      default:   wb_src = alu_result_EX;
    endcase
  end

  // EX/WB capture: accepted instructions load, stalled cycles insert a bubble
  always_comb begin
    regwrite_d  = 1'b0;
    writeaddr_d = writeaddr_q;
    writedata_d = writedata_q;
    gpio_d      = gpio_q;
    if (accept) begin
      regwrite_d  = regwrite_EX & (rd_EX != 5'd0);
      writeaddr_d = rd_EX;
      writedata_d = wb_src;
      if (GPIO_out_en_EX) gpio_d = opb_EX;
    end
  end

  // HI/LO take the signed-corrected product in the multiplier's final cycle
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (mul_done) begin
      hi_d = mul_product[2*DATA_W-1:DATA_W];
      lo_d = mul_product[DATA_W-1:0];
    end
  end

  // Architectural registers
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q  <= 1'b0;
      writeaddr_q <= '0;
      writedata_q <= '0;
      gpio_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      regwrite_q  <= regwrite_d;
      writeaddr_q <= writeaddr_d;
      writedata_q <= writedata_d;
      gpio_q      <= gpio_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign regwrite_WB  = regwrite_q;
  assign writeaddr_WB = writeaddr_q;
  assign writedata_WB = writedata_q;
  assign GPIO_OUT     = gpio_q;
  assign mul_busy     = mul_busy_w;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed table, multi-cycle sequences, random traffic.
module tb_writeback_stage;

  localparam int LAT = 32 + 1;  // edges from multiply acceptance to HI/LO update

  logic        clk;
  logic        rst;
  logic [3:0]  alu_op_EX;
  logic [31:0] alu_result_EX, opa_EX, opb_EX;
  logic        enhilo_EX;
  logic [1:0]  regsel_EX;
  logic        regwrite_EX;
  logic [4:0]  rd_EX;
  logic        GPIO_out_en_EX;
  logic        stall_EX, regwrite_WB, mul_busy;
  logic [4:0]  writeaddr_WB;
  logic [31:0] writedata_WB, GPIO_OUT;

  writeback_stage #(.DATA_W(32), .MUL_STEPS(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_op_EX      (alu_op_EX),
    .alu_result_EX  (alu_result_EX),
    .opa_EX         (opa_EX),
    .opb_EX         (opb_EX),
    .enhilo_EX      (enhilo_EX),
    .regsel_EX      (regsel_EX),
    .regwrite_EX    (regwrite_EX),
    .rd_EX          (rd_EX),
    .GPIO_out_en_EX (GPIO_out_en_EX),
    .stall_EX       (stall_EX),
    .regwrite_WB    (regwrite_WB),
    .writeaddr_WB   (writeaddr_WB),
    .writedata_WB   (writedata_WB),
    .GPIO_OUT       (GPIO_OUT),
    .mul_busy       (mul_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural state plus a latency countdown for the pending product
  logic [31:0] m_hi, m_lo, m_data, m_gpio;
  logic        m_rw;
  logic [4:0]  m_addr;
  logic [63:0] m_prod;
  int          m_left;

  typedef struct {
    logic [1:0]  sel;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        gpio;
    logic [31:0] b;
    logic        exp_rw;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [31:0] exp_gpio;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_product(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (op == 4'b0110) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return 64'(ua * ub);
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] a,
                       input logic [31:0] b, input logic en, input logic [1:0] sel,
                       input logic rw, input logic [4:0] rd, input logic gpio);
    alu_op_EX      = op;
    alu_result_EX  = alu;
    opa_EX         = a;
    opb_EX         = b;
    enhilo_EX      = en;
    regsel_EX      = sel;
    regwrite_EX    = rw;
    rd_EX          = rd;
    GPIO_out_en_EX = gpio;
  endtask

  task automatic nop();
    drive(4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0);
  endtask

  // One clock: check stall against the model, advance the model at the edge, check outputs after it.
  task automatic step();
    logic es, acc;
    #1;
    es = (m_left > 0) && (enhilo_EX || regsel_EX == 2'd1 || regsel_EX == 2'd2);
    check("stall_EX", 64'(stall_EX), 64'(es));
    @(posedge clk);
    if (rst) begin
      m_rw = 1'b0; m_addr = 5'd0; m_data = 32'h0; m_gpio = 32'h0;
      m_hi = 32'h0; m_lo = 32'h0; m_left = 0;
    end else begin
      acc = !es;
      if (acc) begin
        m_rw   = regwrite_EX && (rd_EX != 5'd0);
        m_addr = rd_EX;
        m_data = (regsel_EX == 2'd1) ? m_hi : (regsel_EX == 2'd2) ? m_lo : alu_result_EX;
        if (GPIO_out_en_EX) m_gpio = opb_EX;
      end else begin
        m_rw = 1'b0;
      end
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) {m_hi, m_lo} = m_prod;
      end else if (acc && enhilo_EX) begin
        m_prod = ref_product(alu_op_EX, opa_EX, opb_EX);
        m_left = LAT;
      end
    end
    @(negedge clk);
    check("regwrite_WB", 64'(regwrite_WB), 64'(m_rw));
    check("writeaddr_WB", 64'(writeaddr_WB), 64'(m_addr));
    check("writedata_WB", 64'(writedata_WB), 64'(m_data));
    check("GPIO_OUT", 64'(GPIO_OUT), 64'(m_gpio));
    check("mul_busy", 64'(mul_busy), 64'(m_left > 0));
    check("HI", 64'(dut.hi_q), 64'(m_hi));
    check("LO", 64'(dut.lo_q), 64'(m_lo));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stalls;
    logic [31:0] ra, rb;

    //            sel   rw    rd     alu           gpio  b             erw   eaddr  edata         egpio
    vecs[0] = '{2'd0, 1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 32'h0,        1'b1, 5'd3,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{2'd0, 1'b1, 5'd0,  32'h00000055, 1'b0, 32'h0,        1'b0, 5'd0,  32'h00000055, 32'h0};
    vecs[2] = '{2'd0, 1'b0, 5'd9,  32'h00000001, 1'b1, 32'h000000A5, 1'b0, 5'd9,  32'h00000001, 32'h000000A5};
    vecs[3] = '{2'd1, 1'b1, 5'd4,  32'h00000999, 1'b0, 32'h0,        1'b1, 5'd4,  32'h00000000, 32'h000000A5};
    vecs[4] = '{2'd2, 1'b1, 5'd5,  32'h00000888, 1'b0, 32'h0,        1'b1, 5'd5,  32'h00000000, 32'h000000A5};
    vecs[5] = '{2'd3, 1'b1, 5'd6,  32'h00000077, 1'b1, 32'h5A5A0000, 1'b1, 5'd6,  32'h00000077, 32'h5A5A0000};
    vecs[6] = '{2'd0, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b1, 5'd31, 32'hFFFFFFFF, 32'h5A5A0000};

    // Reset
    nop();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_rw = 1'b0; m_addr = 5'd0; m_data = 32'h0; m_gpio = 32'h0;
    m_hi = 32'h0; m_lo = 32'h0; m_left = 0; m_prod = 64'h0;
    check("rst_regwrite", 64'(regwrite_WB), 64'h0);
    check("rst_writeaddr", 64'(writeaddr_WB), 64'h0);
    check("rst_writedata", 64'(writedata_WB), 64'h0);
    check("rst_gpio", 64'(GPIO_OUT), 64'h0);
    check("rst_mul_busy", 64'(mul_busy), 64'h0);
    check("rst_stall", 64'(stall_EX), 64'h0);

    // Directed table: single-cycle behaviour with the multiplier idle
    for (int i = 0; i < 7; i++) begin
      drive(4'h0, vecs[i].alu, 32'h0, vecs[i].b, 1'b0, vecs[i].sel, vecs[i].rw, vecs[i].rd,
            vecs[i].gpio);
      step();
      check($sformatf("vec%0d_regwrite", i), 64'(regwrite_WB), 64'(vecs[i].exp_rw));
      check($sformatf("vec%0d_writeaddr", i), 64'(writeaddr_WB), 64'(vecs[i].exp_addr));
      check($sformatf("vec%0d_writedata", i), 64'(writedata_WB), 64'(vecs[i].exp_data));
      check($sformatf("vec%0d_gpio", i), 64'(GPIO_OUT), 64'(vecs[i].exp_gpio));
    end

    // MULTU 0xFFFFFFFF x 2: HI/LO change exactly on edge N+33
    drive(4'b0111, 32'h0, 32'hFFFFFFFF, 32'h2, 1'b1, 2'd0, 1'b0, 5'd0, 1'b0);
    step();
    check("multu_busy_start", 64'(mul_busy), 64'h1);
    for (int k = 1; k <= 32; k++) begin
      nop();
      step();
    end
    check("multu_hi_n32", 64'(dut.hi_q), 64'h0);
    check("multu_busy_n32", 64'(mul_busy), 64'h1);
    nop();
    step();
    check("multu_hi_n33", 64'(dut.hi_q), 64'h00000001);
    check("multu_lo_n33", 64'(dut.lo_q), 64'hFFFFFFFE);
    check("multu_busy_n33", 64'(mul_busy), 64'h0);

    // MULT -3 x 5 followed immediately by mflo
    drive(4'b0110, 32'h0, 32'hFFFFFFFD, 32'h5, 1'b1, 2'd0, 1'b0, 5'd0, 1'b0);
    step();
    drive(4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd2, 1'b1, 5'd8, 1'b0);
    stalls = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (stall_EX !== 1'b1) break;
      stalls++;
      step();
    end
    check("mflo_stall_cycles", 64'(stalls), 64'd33);
    step();
    check("mflo_data", 64'(writedata_WB), 64'hFFFFFFF1);
    check("mflo_regwrite", 64'(regwrite_WB), 64'h1);
    check("mflo_addr", 64'(writeaddr_WB), 64'd8);
    check("mult_neg_hi", 64'(dut.hi_q), 64'hFFFFFFFF);

    // ALU instruction flows past a busy multiplier
    drive(4'b0110, 32'h0, 32'd123, 32'd456, 1'b1, 2'd0, 1'b0, 5'd0, 1'b0);
    step();
    drive(4'h0, 32'h1234, 32'h0, 32'h0, 1'b0, 2'd0, 1'b1, 5'd7, 1'b0);
    #1;
    check("add_no_stall", 64'(stall_EX), 64'h0);
    step();
    check("add_regwrite", 64'(regwrite_WB), 64'h1);
    check("add_addr", 64'(writeaddr_WB), 64'd7);
    check("add_data", 64'(writedata_WB), 64'h1234);
    check("add_busy", 64'(mul_busy), 64'h1);
    for (int k = 0; k < 33; k++) begin
      nop();
      step();
    end
    check("mult_small_lo", 64'(dut.lo_q), 64'h0000DB18);
    check("mult_small_hi", 64'(dut.hi_q), 64'h0);

    // Most negative x most negative
    drive(4'b0110, 32'h0, 32'h80000000, 32'h80000000, 1'b1, 2'd0, 1'b0, 5'd0, 1'b0);
    step();
    for (int k = 0; k < 33; k++) begin
      nop();
      step();
    end
    check("mult_min_hi", 64'(dut.hi_q), 64'h40000000);
    check("mult_min_lo", 64'(dut.lo_q), 64'h0);

    // Reset 10 cycles into a MULT, with a GPIO write on the reset edge
    drive(4'h0, 32'h0, 32'h0, 32'h33, 1'b0, 2'd0, 1'b0, 5'd0, 1'b1);
    step();
    drive(4'b0110, 32'h0, 32'd7, 32'd9, 1'b1, 2'd0, 1'b0, 5'd0, 1'b0);
    step();
    for (int k = 0; k < 9; k++) begin
      nop();
      step();
    end
    drive(4'h0, 32'h0, 32'h0, 32'hFF, 1'b0, 2'd0, 1'b0, 5'd0, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_hi", 64'(dut.hi_q), 64'h0);
    check("abort_lo", 64'(dut.lo_q), 64'h0);
    check("abort_busy", 64'(mul_busy), 64'h0);
    check("abort_gpio", 64'(GPIO_OUT), 64'h0);
    drive(4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd1, 1'b1, 5'd2, 1'b0);
    #1;
    check("abort_mfhi_stall", 64'(stall_EX), 64'h0);
    step();
    check("abort_mfhi_data", 64'(writedata_WB), 64'h0);
    check("abort_mfhi_regwrite", 64'(regwrite_WB), 64'h1);
    for (int k = 0; k < 34; k++) begin
      nop();
      step();
    end
    check("abort_no_late_lo", 64'(dut.lo_q), 64'h0);

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 3))
        0:       ra = 32'h80000000;
        1:       ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
      if ($urandom_range(0, 7) == 0)
        drive(($urandom_range(0, 1) == 1) ? 4'b0110 : 4'b0111, $urandom, ra, rb, 1'b1,
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 3) == 0));
      else
        drive(4'($urandom_range(0, 15)), $urandom, ra, rb, 1'b0, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 3) == 0));
      rst = ($urandom_range(0, 149) == 0);
      step();
      rst = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, datapath width; all 32-bit ports below scale with it.
REQ-002 SHALL provide parameter MUL_STEPS, default 32, multiplier iterations per mult; equals DATA_W.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 alu_op_EX  input  4  EX operation; 4'b0110 = MULT (signed), 4'b0111 = MULTU (unsigned).
REQ-006 alu_result_EX  input  32  ALU result of the EX instruction.
REQ-007 opa_EX, opb_EX  input  32 each  rs/rt operand values; multiplier sources; opb_EX is also the GPIO write data.
REQ-008 enhilo_EX  input  1  EX instruction is mult/multu.
REQ-009 regsel_EX  input  2  0 = ALU result, 1 = HI (mfhi), 2 = LO (mflo), 3 = treated as 0.
REQ-010 regwrite_EX  input  1  EX instruction writes a register.
REQ-011 rd_EX  input  5  destination register number.
REQ-012 GPIO_out_en_EX  input  1  EX instruction is a GPIO write.
REQ-013 stall_EX  output  1  combinational; EX instruction not accepted this cycle.
REQ-014 regwrite_WB  output  1  register-file write enable.
REQ-015 writeaddr_WB  output  5  register-file write address.
REQ-016 writedata_WB  output  32  register-file write data.
REQ-017 GPIO_OUT  output  32  registered GPIO output.
REQ-018 mul_busy  output  1  multiplier not IDLE.

Function
REQ-019 SHALL keep architectural HI and LO registers, 32 bits each.
REQ-020 SHALL drive stall_EX = 1 when mul FSM is not IDLE and (enhilo_EX = 1 or regsel_EX is 1 or 2), else 0.
REQ-021 Accepted instruction = any cycle with stall_EX = 0; on each edge the EX/WB register SHALL capture regwrite_WB = regwrite_EX & (rd_EX != 0), writeaddr_WB = rd_EX, writedata_WB = selected source (1-cycle latency).
REQ-022 On a stalled cycle, the EX/WB register SHALL capture a bubble: regwrite_WB = 0; writeaddr_WB and writedata_WB hold.
REQ-023 Source select: regsel 1 -> current HI, 2 -> current LO, 0 or 3 -> alu_result_EX.
REQ-024 Non-HI/LO instructions SHALL proceed unstalled while multiplier is busy.
REQ-025 Mul FSM states: IDLE, MUL, FIN.
REQ-026 IDLE -> MUL on accepted edge with enhilo_EX = 1: latch operand magnitudes (signed when alu_op_EX = 0110, raw when 0111), latch result sign = sign(a) XOR sign(b) for signed only, clear 64-bit accumulator, clear step counter.
REQ-027 MUL: one shift-add step per edge; after step MUL_STEPS (counter = MUL_STEPS-1) go to FIN.
REQ-028 FIN -> IDLE on next edge: {HI,LO} <= accumulator, two's-complement negated if latched sign = 1.
REQ-029 Total latency: accept edge N, HI/LO updated on edge N+MUL_STEPS+1; mfhi/mflo accepted on or after that edge returns the new product.
REQ-030 Product SHALL be the full 64-bit result; MULT of 0x80000000 x 0x80000000 = 0x4000000000000000.
REQ-031 GPIO_OUT SHALL load opb_EX on accepted edge with GPIO_out_en_EX = 1, else hold.
REQ-032 mul_busy = 1 in MUL and FIN.

Reset
REQ-033 On rst edge: regwrite_WB = 0, writeaddr_WB = 0, writedata_WB = 0, GPIO_OUT = 0, HI = LO = 0, FSM = IDLE, counter = 0.
REQ-034 rst mid-multiply SHALL abort it: no HI/LO update; stall_EX = 0 and mul_busy = 0 in the cycle after reset.
REQ-035 rst SHALL take priority over all same-edge updates.

Structure
REQ-036 Shared package mips_pkg SHALL hold ALU op codes (MULT, MULTU), regsel encodings, mul FSM state typedef and DATA_W.
REQ-037 Sub-module mul_iter SHALL hold the iterative multiplier (FSM, counter, accumulator, sign fix-up) with start/busy/done/product ports; the top module holds the EX/WB register, HI/LO, mux, stall and GPIO logic.

Verification
REQ-038 Bench SHALL cover: MULTU 0xFFFFFFFF x 2 -> edge N+33: HI = 0x00000001, LO = 0xFFFFFFFE.
REQ-039 Bench SHALL cover: MULT -3 x 5, then mflo issued next cycle -> stall_EX = 1 for 33 cycles, then writedata_WB = 0xFFFFFFF1, HI = 0xFFFFFFFF.
REQ-040 Bench SHALL cover: add to rd = 7 (alu_result 0x1234) during busy multiply -> no stall; next cycle regwrite_WB = 1, writeaddr_WB = 7, writedata_WB = 0x1234.
REQ-041 Bench SHALL cover: regwrite_EX = 1 with rd_EX = 0 -> regwrite_WB = 0; GPIO write opb = 0xA5 -> GPIO_OUT = 0x000000A5 next cycle.
REQ-042 Bench SHALL cover: rst asserted 10 cycles into a MULT -> HI = LO = 0, mul_busy = 0, GPIO_OUT = 0; a subsequent mfhi is not stalled and returns 0.
